// File: rtl/udma_tx_wrr_arbiter_pkg.sv
// Shared constants and helpers for the uDMA TX weighted round-robin arbiter.
// Holds default weight width, starvation threshold and a modulo-N increment.
package udma_arb_pkg;

  localparam int unsigned ARB_WEIGHT_W     = 4;
  localparam int unsigned ARB_STARVE_LIMIT = 255;

  function automatic int unsigned mod_inc(
    input int unsigned idx,
    input int unsigned n
  );
    return (idx + 1 >= n) ? 0 : idx + 1;
  endfunction

endpackage

// File: rtl/udma_tx_wrr_arbiter_if.sv
// Request/grant bundle between the TX channels and the WRR arbiter.
// The arbiter takes the slave side; the channel/FIFO side is the master.
interface udma_tx_wrr_arbiter_if
  import udma_arb_pkg::*;
#(
  parameter int unsigned N        = 16,
  parameter int unsigned S        = $clog2(N),
  parameter int unsigned WEIGHT_W = ARB_WEIGHT_W
);

  logic [N-1:0]               req_i;
  logic [N-1:0][WEIGHT_W-1:0] weight_i;
  logic                       grant_ack_i;
  logic [N-1:0]               grant_o;
  logic [S-1:0]               grant_idx_o;
  logic                       any_grant_o;
  logic [N-1:0]               starve_o;

  modport slave (
    input  req_i,
    input  weight_i,
    input  grant_ack_i,
    output grant_o,
    output grant_idx_o,
    output any_grant_o,
    output starve_o
  );

  modport master (
    output req_i,
    output weight_i,
    output grant_ack_i,
    input  grant_o,
    input  grant_idx_o,
    input  any_grant_o,
    input  starve_o
  );

endinterface

// File: rtl/udma_tx_wrr_arbiter_rr_pick.sv
// First-set search of an N-bit vector starting at a given index,
// wrapping from N-1 back to 0.
module udma_rr_pick
  import udma_arb_pkg::*;
#(
  parameter int unsigned N = 16,
  parameter int unsigned S = $clog2(N)
) (
  input  logic [N-1:0] vec,
  input  logic [S-1:0] start,
  output logic [N-1:0] onehot,
  output logic [S-1:0] idx,
  output logic         found
);

  always_comb begin
    int unsigned j;
    logic [S-1:0] js;
    onehot = '0;
    idx    = '0;
    found  = 1'b0;
    j      = 32'(start);
    for (int unsigned k = 0; k < N; k++) begin
      js = S'(j);
      if (!found && vec[js]) begin
        found      = 1'b1;
        onehot[js] = 1'b1;
        idx        = js;
      end
      j = mod_inc(j, N);
    end
  end

endmodule

// File: rtl/udma_tx_wrr_arbiter.sv
// Weighted round-robin arbiter for the uDMA TX L2 read-request path.
// Define UDMA_ARB_STARVE_MON_EN to build the per-channel starvation monitor.
module udma_tx_wrr_arbiter
  import udma_arb_pkg::*;
#(
  parameter int unsigned N            = 16,
  parameter int unsigned S            = $clog2(N),
  parameter int unsigned WEIGHT_W     = ARB_WEIGHT_W,
  parameter int unsigned STARVE_LIMIT = ARB_STARVE_LIMIT
) (
  input logic                  clk_i,
  input logic                  rst_i,
  udma_tx_wrr_arbiter_if.slave arb
);

  logic [S-1:0]        r_owner;
  logic [S-1:0]        r_ptr;
  logic [WEIGHT_W-1:0] r_credit;
  logic                r_active;

  logic [S-1:0]        n_owner;
  logic [S-1:0]        n_ptr;
  logic [WEIGHT_W-1:0] n_credit;
  logic                n_active;

  logic                own_hold;
  logic [S-1:0]        pick_start;
  logic [N-1:0]        pick_oh;
  logic [S-1:0]        pick_idx;
  logic                pick_found;

  logic [N-1:0]        gnt;
  logic [S-1:0]        gnt_idx;
  logic                gnt_any;
  logic                fire;
  logic [WEIGHT_W-1:0] w_sel;
  logic [WEIGHT_W-1:0] w_m1;
  logic [S-1:0]        g_inc;

  // Owner keeps the port only while it still requests.
  assign own_hold   = r_active & arb.req_i[r_owner];
  assign pick_start = r_active ? S'(mod_inc(32'(r_owner), N))
                               : r_ptr;

  udma_rr_pick #(
    .N (N),
    .S (S)
  ) u_pick (
    .vec    (arb.req_i),
    .start  (pick_start),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .found  (pick_found)
  );

  always_comb begin
    gnt     = '0;
    gnt_idx = '0;
    gnt_any = 1'b0;
    if (!rst_i) begin
      if (own_hold) begin
        gnt[r_owner] = 1'b1;
        gnt_idx      = r_owner;
        gnt_any      = 1'b1;
      end else if (pick_found) begin
        gnt     = pick_oh;
        gnt_idx = pick_idx;
        gnt_any = 1'b1;
      end
    end
  end

  assign arb.grant_o     = gnt;
  assign arb.grant_idx_o = gnt_idx;
  assign arb.any_grant_o = gnt_any;

  assign fire  = arb.grant_ack_i & gnt_any;
  assign w_sel = arb.weight_i[gnt_idx];
  assign w_m1  = (w_sel == '0) ? '0 : w_sel - WEIGHT_W'(1);
  assign g_inc = S'(mod_inc(32'(gnt_idx), N));

  always_comb begin
    n_owner  = r_owner;
    n_credit = r_credit;
    n_active = r_active;
    n_ptr    = r_ptr;
    if (fire) begin
      if (r_active && gnt_idx == r_owner) begin
        n_credit = r_credit - WEIGHT_W'(1);
        if (n_credit == '0) begin
          n_active = 1'b0;
          n_ptr    = g_inc;
        end
      end else begin
        n_owner  = gnt_idx;
        n_credit = w_m1;
        if (w_m1 == '0) begin
          n_active = 1'b0;
          n_ptr    = g_inc;
        end else begin
          n_active = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_owner  <= '0;
      r_credit <= '0;
      r_active <= 1'b0;
      r_ptr    <= '0;
    end else begin
      r_owner  <= n_owner;
      r_credit <= n_credit;
      r_active <= n_active;
      r_ptr    <= n_ptr;
    end
  end

`ifdef UDMA_ARB_STARVE_MON_EN
  localparam int unsigned CW = $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIM = CW'(STARVE_LIMIT);

  logic [N-1:0][CW-1:0] r_wait;
  logic [N-1:0]         starve;

  // Saturating wait count; flag holds until the counter clears.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_wait <= '0;
    end else begin
      for (int i = 0; i < N; i++) begin
        if (!arb.req_i[i] || (fire && gnt[i])) begin
          r_wait[i] <= '0;
        end else if (r_wait[i] != LIM) begin
          r_wait[i] <= r_wait[i] + CW'(1);
        end
      end
    end
  end

  always_comb begin
    starve = '0;
    for (int i = 0; i < N; i++) begin
      starve[i] = (r_wait[i] == LIM);
    end
  end

  assign arb.starve_o = starve;
`else
  assign arb.starve_o = '0;
`endif

endmodule

// File: tb/tb_udma_tx_wrr_arbiter.sv
// Self-checking bench for udma_tx_wrr_arbiter (N=4) with a
// quantum-level reference model and randomized traffic.
module tb_udma_tx_wrr_arbiter;

  localparam int N   = 4;
  localparam int S   = 2;
  localparam int WW  = 4;
  localparam int LIM = 8;
`ifdef UDMA_ARB_STARVE_MON_EN
  localparam bit MON = 1'b1;
`else
  localparam bit MON = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  udma_tx_wrr_arbiter_if #(.N(N), .S(S), .WEIGHT_W(WW)) bus ();

  udma_tx_wrr_arbiter #(
    .N            (N),
    .S            (S),
    .WEIGHT_W     (WW),
    .STARVE_LIMIT (LIM)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .arb   (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  // Model: who holds the port, grants left in its quantum,
  // where the next search starts, and per-channel wait cycles.
  int m_owner;
  int m_left;
  int m_ptr;
  bit m_active;
  int m_wait [N];

  function automatic void model_reset();
    m_owner  = 0;
    m_left   = 0;
    m_ptr    = 0;
    m_active = 1'b0;
    for (int i = 0; i < N; i++) m_wait[i] = 0;
  endfunction

  function automatic int model_pick(input logic [N-1:0] r);
    int start;
    if (m_active && r[m_owner]) return m_owner;
    start = m_active ? (m_owner + 1) % N : m_ptr;
    for (int k = 0; k < N; k++)
      if (r[(start + k) % N]) return (start + k) % N;
    return -1;
  endfunction

  function automatic logic [N-1:0] model_starve();
    logic [N-1:0] s;
    s = '0;
    for (int i = 0; i < N; i++) s[i] = MON && (m_wait[i] == LIM);
    return s;
  endfunction

  function automatic logic [N-1:0] oh(input int g);
    logic [N-1:0] v;
    v = '0;
    if (g >= 0) v[g] = 1'b1;
    return v;
  endfunction

  // Advance the model across the coming clock edge.
  function automatic void model_commit(input int g);
    logic [N-1:0] r;
    bit a;
    int w;
    r = bus.req_i;
    a = bus.grant_ack_i;
    for (int i = 0; i < N; i++) begin
      if (!r[i] || (a && g == i)) m_wait[i] = 0;
      else if (m_wait[i] < LIM) m_wait[i]++;
    end
    if (!a || g < 0) return;
    w = int'(bus.weight_i[g]);
    if (w == 0) w = 1;
    if (m_active && g == m_owner) begin
      m_left--;
      if (m_left == 0) begin
        m_active = 1'b0;
        m_ptr    = (g + 1) % N;
      end
    end else begin
      m_owner  = g;
      m_left   = w - 1;
      m_active = (m_left != 0);
      if (!m_active) m_ptr = (g + 1) % N;
    end
  endfunction

  task automatic apply(input logic [N-1:0] r, input logic a);
    @(negedge clk);
    bus.req_i       = r;
    bus.grant_ack_i = a;
    #1;
  endtask

  task automatic set_weights(input int w0, input int w1,
                             input int w2, input int w3);
    bus.weight_i[0] = WW'(w0);
    bus.weight_i[1] = WW'(w1);
    bus.weight_i[2] = WW'(w2);
    bus.weight_i[3] = WW'(w3);
  endtask

  task automatic do_reset();
    rst             = 1'b1;
    bus.req_i       = '0;
    bus.grant_ack_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    logic [N-1:0] pats [2];
    pats[0] = 4'b1111;
    pats[1] = 4'b1010;
    rst = 1'b1;
    set_weights(1, 1, 1, 1);
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      bus.req_i       = pats[k];
      bus.grant_ack_i = 1'b1;
      #1;
      n_checks++;
      if (bus.grant_o !== '0 || bus.grant_idx_o !== '0 ||
          bus.any_grant_o !== 1'b0 || bus.starve_o !== '0) begin
        n_fail++;
        $display("FAIL reset[%0d]: grant=%b idx=%0d any=%b starve=%b, required all 0",
                 k, bus.grant_o, bus.grant_idx_o, bus.any_grant_o, bus.starve_o);
      end
    end
    do_reset();
  endtask

  task automatic test_rr_equal();
    int seq [5] = '{0, 1, 2, 3, 0};
    do_reset();
    set_weights(1, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      apply(4'b1111, 1'b1);
      n_checks++;
      if (bus.grant_idx_o !== S'(seq[k]) || bus.grant_o !== oh(seq[k]) ||
          bus.any_grant_o !== 1'b1) begin
        n_fail++;
        $display("FAIL rr_equal[%0d]: grant=%b idx=%0d any=%b, required idx=%0d",
                 k, bus.grant_o, bus.grant_idx_o, bus.any_grant_o, seq[k]);
      end
      model_commit(model_pick(bus.req_i));
    end
  endtask

  task automatic test_weighted();
    int seq [8] = '{0, 0, 0, 1, 0, 0, 0, 1};
    do_reset();
    set_weights(3, 1, 1, 1);
    for (int k = 0; k < 8; k++) begin
      apply(4'b0011, 1'b1);
      n_checks++;
      if (bus.grant_idx_o !== S'(seq[k]) || bus.grant_o !== oh(seq[k])) begin
        n_fail++;
        $display("FAIL weighted[%0d]: grant=%b idx=%0d, required idx=%0d",
                 k, bus.grant_o, bus.grant_idx_o, seq[k]);
      end
      model_commit(model_pick(bus.req_i));
    end
  endtask

  task automatic test_owner_drop();
    logic [N-1:0] reqs [5];
    int seq [5] = '{0, 0, 1, 2, 0};
    reqs[0] = 4'b0001;
    reqs[1] = 4'b0001;
    reqs[2] = 4'b0110;
    reqs[3] = 4'b0111;
    reqs[4] = 4'b0111;
    do_reset();
    set_weights(4, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      apply(reqs[k], 1'b1);
      n_checks++;
      if (bus.grant_idx_o !== S'(seq[k]) || bus.grant_o !== oh(seq[k])) begin
        n_fail++;
        $display("FAIL owner_drop[%0d]: grant=%b idx=%0d, required idx=%0d",
                 k, bus.grant_o, bus.grant_idx_o, seq[k]);
      end
      model_commit(model_pick(bus.req_i));
    end
  endtask

  task automatic test_ack_stall();
    do_reset();
    set_weights(1, 1, 1, 1);
    for (int k = 0; k < 5; k++) begin
      apply(4'b0101, 1'b0);
      n_checks++;
      if (bus.grant_o !== 4'b0001 || bus.grant_idx_o !== 2'd0) begin
        n_fail++;
        $display("FAIL ack_stall[%0d]: grant=%b, required 0001", k, bus.grant_o);
      end
      model_commit(model_pick(bus.req_i));
    end
    apply(4'b0101, 1'b1);
    n_checks++;
    if (bus.grant_o !== 4'b0001) begin
      n_fail++;
      $display("FAIL ack_first: grant=%b, required 0001", bus.grant_o);
    end
    model_commit(model_pick(bus.req_i));
    apply(4'b0101, 1'b1);
    n_checks++;
    if (bus.grant_o !== 4'b0100 || bus.grant_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL ack_advance: grant=%b idx=%0d, required 0100 idx 2",
               bus.grant_o, bus.grant_idx_o);
    end
    model_commit(model_pick(bus.req_i));
  endtask

  task automatic test_reset_mid();
    do_reset();
    set_weights(1, 1, 3, 1);
    apply(4'b0100, 1'b1);
    n_checks++;
    if (bus.grant_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_setup: idx=%0d, required 2", bus.grant_idx_o);
    end
    model_commit(model_pick(bus.req_i));
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.grant_o !== '0 || bus.grant_idx_o !== '0 ||
        bus.any_grant_o !== 1'b0 || bus.starve_o !== '0) begin
      n_fail++;
      $display("FAIL mid_reset: grant=%b idx=%0d any=%b starve=%b, required all 0",
               bus.grant_o, bus.grant_idx_o, bus.any_grant_o, bus.starve_o);
    end
    bus.req_i       = '0;
    bus.grant_ack_i = 1'b0;
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    apply(4'b1100, 1'b1);
    n_checks++;
    if (bus.grant_o !== 4'b0100 || bus.grant_idx_o !== 2'd2) begin
      n_fail++;
      $display("FAIL mid_restart: grant=%b idx=%0d, required 0100 idx 2",
               bus.grant_o, bus.grant_idx_o);
    end
    model_commit(model_pick(bus.req_i));
  endtask

  task automatic test_idle();
    int exp;
    for (int k = 0; k < 3; k++) begin
      apply(4'b0000, 1'b1);
      n_checks++;
      if (bus.grant_o !== '0 || bus.grant_idx_o !== '0 ||
          bus.any_grant_o !== 1'b0) begin
        n_fail++;
        $display("FAIL idle[%0d]: grant=%b idx=%0d any=%b, required all 0",
                 k, bus.grant_o, bus.grant_idx_o, bus.any_grant_o);
      end
      model_commit(model_pick(bus.req_i));
    end
    apply(4'b1011, 1'b1);
    exp = model_pick(bus.req_i);
    n_checks++;
    if (bus.grant_o !== oh(exp) || bus.grant_idx_o !== S'(exp)) begin
      n_fail++;
      $display("FAIL idle_resume: grant=%b idx=%0d, required idx=%0d",
               bus.grant_o, bus.grant_idx_o, exp);
    end
    model_commit(exp);
  endtask

  task automatic test_starve();
    logic [N-1:0] want;
    int exp;
    do_reset();
    set_weights(15, 1, 1, 1);
    for (int k = 0; k < 20; k++) begin
      apply(4'b0011, 1'b1);
      exp  = model_pick(bus.req_i);
      want = {2'b00, MON && k >= 8 && k <= 15, 1'b0};
      n_checks++;
      if (bus.starve_o !== want || bus.grant_o !== oh(exp)) begin
        n_fail++;
        $display("FAIL starve[%0d]: starve=%b grant=%b, required starve=%b grant=%b",
                 k, bus.starve_o, bus.grant_o, want, oh(exp));
      end
      model_commit(exp);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [N-1:0] ws;
    logic a;
    int exp;
    do_reset();
    set_weights(2, 1, 3, 0);
    for (int k = 0; k < 400; k++) begin
      if ($urandom_range(0, 7) == 0)
        bus.weight_i[$urandom_range(0, N - 1)] = WW'($urandom_range(0, 5));
      r = ($urandom_range(0, 4) == 0) ? '0 : N'($urandom);
      a = ($urandom_range(0, 3) != 0);
      apply(r, a);
      exp = model_pick(bus.req_i);
      ws  = model_starve();
      n_checks++;
      if (bus.grant_o !== oh(exp) || bus.any_grant_o !== (exp >= 0) ||
          bus.grant_idx_o !== S'(exp < 0 ? 0 : exp) || bus.starve_o !== ws) begin
        n_fail++;
        $display("FAIL random[%0d]: req=%b ack=%b grant=%b idx=%0d starve=%b, required grant=%b starve=%b",
                 k, r, a, bus.grant_o, bus.grant_idx_o, bus.starve_o, oh(exp), ws);
      end
      model_commit(exp);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_rr_equal();
    test_weighted();
    test_owner_drop();
    test_ack_stall();
    test_reset_mid();
    test_idle();
    test_starve();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
